mem_dump_engine: RTL and testbench
==================================

MEM_DUMP_ENGINE -- requirements
Module: mem_dump_engine

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit data-memory words dumped.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0, byte address of word 0.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port start_i  input  1  one-cycle dump request; honoured only in IDLE.
REQ-006 SHALL have port abort_i  input  1  cancel dump, flush buffer.
REQ-007 SHALL have port mem_ce_o  output  1  data-memory read enable.
REQ-008 SHALL have port mem_addr_o  output  32  byte address, BASE_ADDR + 4*index.
REQ-009 SHALL have port mem_data_i  input  32  combinational read data, valid in the same cycle as mem_ce_o.
REQ-010 SHALL have port dump_valid_o  output  1  stream word available.
REQ-011 SHALL have port dump_ready_i  input  1  consumer accepts word.
REQ-012 SHALL have port dump_data_o  output  32  word value.
REQ-013 SHALL have port dump_index_o  output  $clog2(DEPTH)  word index of dump_data_o.
REQ-014 SHALL have port busy_o  output  1  high in READ or DRAIN.
REQ-015 SHALL have port done_o  output  1  one-cycle pulse when the final word is accepted.

Function
REQ-016 SHALL implement FSM states IDLE, READ, DRAIN.
REQ-017 IDLE -> READ SHALL occur on start_i; read index SHALL be cleared to 0.
REQ-018 SHALL contain a 2-entry FIFO holding {index, data}; dump_valid_o = FIFO not empty; head drives dump_data_o/dump_index_o.
REQ-019 In READ, mem_ce_o SHALL be high iff FIFO count < 2 or a pop occurs this cycle; mem_addr_o = BASE_ADDR + 4*index.
REQ-020 Each cycle with mem_ce_o high SHALL push mem_data_i and index into the FIFO and increment index.
REQ-021 Pop SHALL occur iff dump_valid_o && dump_ready_i; push and pop in the same cycle SHALL leave count unchanged, including at count 2.
REQ-022 The push of index DEPTH-1 SHALL move READ -> DRAIN; no further reads SHALL be issued.
REQ-023 DRAIN -> IDLE SHALL occur when the last entry is popped; done_o SHALL pulse in the cycle after that pop.
REQ-024 Latency: start_i at cycle N -> mem_ce_o at N+1 -> dump_valid_o at N+2 with index 0.
REQ-025 With dump_ready_i held high, SHALL sustain one word per cycle; DEPTH words SHALL complete with done_o at N+DEPTH+2.
REQ-026 dump_valid_o held high SHALL keep data/index stable until accepted.
REQ-027 abort_i SHALL take priority over every other event: FIFO flushed, mem_ce_o low next cycle, state IDLE, no done_o.
REQ-028 start_i while busy SHALL be ignored.
REQ-029 mem_ce_o low SHALL drive mem_addr_o to 32'h0.
REQ-030 index arithmetic SHALL be $clog2(DEPTH)+1 bits wide so the terminal comparison does not wrap at DEPTH a power of two.

Reset
REQ-031 rst low at a clock edge SHALL force state IDLE, FIFO empty, index 0, regardless of state.
REQ-032 During and after reset all outputs SHALL be 0: mem_ce_o, mem_addr_o, dump_valid_o, dump_data_o, dump_index_o, busy_o, done_o.
REQ-033 Reset mid-dump SHALL discard buffered words; a later start_i SHALL restart from index 0.

Structure
REQ-034 FSM state encoding and the default word size/byte stride (4) SHALL live in the shared SoC package.
REQ-035 The 2-entry FIFO SHALL be a sub-module named dump_fifo2, with its width parameterised.
REQ-036 The engine SHALL NOT issue writes; it attaches to the data-memory port only while the core is held or halted.

Verification
REQ-037 DEPTH=4, memory preset 0xA0..0xA3, ready high, start at cycle 10 -> mem_ce_o at cycles 11-14, valid words 0xA0..0xA3 at cycles 12-15, done_o at cycle 16.
REQ-038 Ready low 5 cycles after start -> at most 2 reads issued, mem_ce_o low thereafter, dump_data_o stable; on release, order preserved with no loss or duplicates.
REQ-039 Ready toggling every cycle over DEPTH=1024 -> 1024 words received, indices 0..1023 in order, exactly one done_o.
REQ-040 abort_i at index 2 with FIFO full -> next cycle dump_valid_o=0, busy_o=0, no done_o; a following start_i begins at index 0.
REQ-041 rst low mid-DRAIN -> all outputs 0 next cycle; start_i pulsed while busy -> ignored, sequence unchanged.

Source files
------------

// File: rtl/mem_dump_engine_pkg.sv
// Shared SoC definitions for the data-memory dump engine: word geometry and FSM encoding.
package mem_dump_engine_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BYTE_STRIDE = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } dump_state_e;

endpackage

// File: rtl/dump_fifo2.sv
// Two-entry FIFO; a push and a pop in the same cycle are accepted even when full.
module dump_fifo2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q;
  logic             rd_q;
  logic [1:0]       cnt_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt_q != 2'd0);
  // When full, the slot being written is the head being popped this cycle.
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/mem_dump_engine.sv
// Streams DEPTH data-memory words out over a valid/ready port, read-only access.
module mem_dump_engine
  import mem_dump_engine_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  output logic                     mem_ce_o,
  output logic [31:0]              mem_addr_o,
  input  logic [31:0]              mem_data_i,
  output logic                     dump_valid_o,
  input  logic                     dump_ready_i,
  output logic [31:0]              dump_data_o,
  output logic [$clog2(DEPTH)-1:0] dump_index_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned ENT_W = IDX_W + WORD_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  dump_state_e      state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             ce_c;
  logic             flush_c;
  logic             pop_c;
  logic [1:0]       fifo_count;
  logic [ENT_W-1:0] head;

  dump_fifo2 #(.WIDTH(ENT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_c),
    .push  (ce_c),
    .pop   (pop_c),
    .wdata ({idx_q[IDX_W-1:0], mem_data_i}),
    .rdata (head),
    .count (fifo_count)
  );

  assign dump_valid_o = (fifo_count != 2'd0);
  assign pop_c        = dump_valid_o && dump_ready_i;
  assign dump_index_o = head[ENT_W-1:WORD_W];
  assign dump_data_o  = head[WORD_W-1:0];
  assign mem_ce_o     = ce_c;
  assign mem_addr_o   = ce_c ? (BASE_ADDR + 32'(idx_q) * 32'(BYTE_STRIDE)) : 32'h0;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next state; abort overrides everything, reset also suppresses the memory enable.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    ce_c    = 1'b0;
    flush_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_READ;
          idx_d   = '0;
        end
      end
      ST_READ: begin
        ce_c = (fifo_count < 2'd2) || pop_c;
        if (ce_c) begin
          idx_d = idx_q + CNT_W'(1);
          if (idx_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop_c && (fifo_count == 2'd1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
      flush_c = 1'b1;
      done_d  = 1'b0;
    end
    if (!rst) ce_c = 1'b0;
  end

endmodule

// File: tb/tb_mem_dump_engine.sv
// Directed bench: small engine (DEPTH=4) for timing/abort/reset, large one (DEPTH=1024) for throttled streaming.
module tb_mem_dump_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, ready;
  logic        ce, valid, busy, done;
  logic [31:0] addr, mem_data, data;
  logic [1:0]  index;

  logic        b_start, b_abort, b_ready;
  logic        b_ce, b_valid, b_busy, b_done;
  logic [31:0] b_addr, b_mem_data, b_data;
  logic [9:0]  b_index;

  int checks = 0;
  int errors = 0;
  int exp_idx, words, reads, dones;
  int b_exp, b_words, b_dones;

  always #5 clk = ~clk;

  mem_dump_engine #(.DEPTH(4), .BASE_ADDR(32'h0000_1000)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
    .mem_ce_o(ce), .mem_addr_o(addr), .mem_data_i(mem_data),
    .dump_valid_o(valid), .dump_ready_i(ready), .dump_data_o(data),
    .dump_index_o(index), .busy_o(busy), .done_o(done)
  );

  mem_dump_engine #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000)) u_big (
    .clk(clk), .rst(rst), .start_i(b_start), .abort_i(b_abort),
    .mem_ce_o(b_ce), .mem_addr_o(b_addr), .mem_data_i(b_mem_data),
    .dump_valid_o(b_valid), .dump_ready_i(b_ready), .dump_data_o(b_data),
    .dump_index_o(b_index), .busy_o(b_busy), .done_o(b_done)
  );

  // Memory images: small holds 0xA0+i, large holds address ^ 0x5A5A0000.
  assign mem_data   = ce ? (32'hA0 + ((addr - 32'h0000_1000) >> 2)) : 32'hDEAD_BEEF;
  assign b_mem_data = b_ce ? (b_addr ^ 32'h5A5A_0000) : 32'hDEAD_BEEF;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_ce"},    32'(ce), 32'h0);
    check_eq({tag, "_addr"},  addr, 32'h0);
    check_eq({tag, "_valid"}, 32'(valid), 32'h0);
    check_eq({tag, "_data"},  data, 32'h0);
    check_eq({tag, "_index"}, 32'(index), 32'h0);
    check_eq({tag, "_busy"},  32'(busy), 32'h0);
    check_eq({tag, "_done"},  32'(done), 32'h0);
  endtask

  task automatic run_to_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      next_cycle();
      mid();
      if (done) seen = 1'b1;
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'h1);
  endtask

  // Every accepted word must be the next index in order with its memory value.
  always @(negedge clk) begin
    if (valid && ready) begin
      check_eq("stream_index", 32'(index), 32'(exp_idx));
      check_eq("stream_data", data, 32'hA0 + 32'(exp_idx));
      exp_idx++;
      words++;
    end
    if (ce) reads++;
    if (done) dones++;
  end

  always @(negedge clk) begin
    if (b_valid && b_ready) begin
      check_eq("big_index", 32'(b_index), 32'(b_exp));
      check_eq("big_data", b_data, (32'h8000_0000 + 32'(b_exp) * 32'd4) ^ 32'h5A5A_0000);
      b_exp++;
      b_words++;
    end
    if (b_done) b_dones++;
  end

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b0;
    exp_idx = 0; words = 0; reads = 0; dones = 0;
    b_exp = 0; b_words = 0; b_dones = 0;
    repeat (3) next_cycle();
    mid();
    check_idle_zero("reset");
    next_cycle();
    rst = 1'b1;
    repeat (5) next_cycle();

    // Full-rate dump: ce N+1..N+4, words N+2..N+5, done N+6.
    start = 1'b1; ready = 1'b1; exp_idx = 0; words = 0;
    mid();
    check_eq("t1_ce_n", 32'(ce), 32'h0);
    next_cycle(); start = 1'b0; mid();
    check_eq("t1_ce_n1", 32'(ce), 32'h1);
    check_eq("t1_addr_n1", addr, 32'h0000_1000);
    check_eq("t1_valid_n1", 32'(valid), 32'h0);
    check_eq("t1_busy_n1", 32'(busy), 32'h1);
    next_cycle(); mid();
    check_eq("t1_valid_n2", 32'(valid), 32'h1);
    check_eq("t1_data_n2", data, 32'hA0);
    check_eq("t1_addr_n2", addr, 32'h0000_1004);
    next_cycle();
    next_cycle(); mid();
    check_eq("t1_addr_n4", addr, 32'h0000_100C);
    next_cycle(); mid();
    check_eq("t1_ce_n5", 32'(ce), 32'h0);
    check_eq("t1_addr_n5", addr, 32'h0);
    check_eq("t1_data_n5", data, 32'hA3);
    check_eq("t1_busy_n5", 32'(busy), 32'h1);
    check_eq("t1_done_n5", 32'(done), 32'h0);
    next_cycle(); mid();
    check_eq("t1_done_n6", 32'(done), 32'h1);
    check_eq("t1_valid_n6", 32'(valid), 32'h0);
    check_eq("t1_busy_n6", 32'(busy), 32'h0);
    next_cycle(); mid();
    check_eq("t1_done_n7", 32'(done), 32'h0);
    check_eq("t1_words", 32'(words), 32'd4);

    // Backpressure: two reads then stall with a stable head.
    next_cycle();
    ready = 1'b0; start = 1'b1; exp_idx = 0; words = 0; reads = 0;
    next_cycle(); start = 1'b0;
    next_cycle();
    for (int k = 3; k <= 5; k++) begin
      next_cycle(); mid();
      check_eq("t2_stall_ce", 32'(ce), 32'h0);
      check_eq("t2_stall_data", data, 32'hA0);
      check_eq("t2_stall_index", 32'(index), 32'h0);
    end
    next_cycle();
    check_eq("t2_reads", 32'(reads), 32'd2);
    ready = 1'b1;
    run_to_done("t2", 20);
    check_eq("t2_words", 32'(words), 32'd4);
    check_eq("t2_total_reads", 32'(reads), 32'd4);

    // Abort with the FIFO full, then restart from index 0.
    next_cycle();
    ready = 1'b0; start = 1'b1;
    next_cycle(); start = 1'b0;
    next_cycle(); next_cycle();
    next_cycle(); abort = 1'b1;
    d0 = dones;
    next_cycle(); abort = 1'b0; mid();
    check_eq("t3_valid", 32'(valid), 32'h0);
    check_eq("t3_busy", 32'(busy), 32'h0);
    check_eq("t3_ce", 32'(ce), 32'h0);
    next_cycle();
    check_eq("t3_no_done", 32'(dones), 32'(d0));
    exp_idx = 0; words = 0; ready = 1'b1; start = 1'b1;
    next_cycle(); start = 1'b0;
    run_to_done("t3_restart", 20);
    check_eq("t3_words", 32'(words), 32'd4);

    // Start while busy is ignored; reset in DRAIN clears all outputs.
    next_cycle();
    exp_idx = 0; words = 0; start = 1'b1;
    next_cycle(); start = 1'b0;
    next_cycle(); start = 1'b1;
    next_cycle(); start = 1'b0; mid();
    check_eq("t4_addr_ignore", addr, 32'h0000_1008);
    next_cycle();
    next_cycle(); ready = 1'b0; rst = 1'b0; mid();
    check_eq("t4_busy_drain", 32'(busy), 32'h1);
    check_eq("t4_ce_in_reset", 32'(ce), 32'h0);
    next_cycle(); mid();
    check_idle_zero("t4_rst");
    check_eq("t4_words", 32'(words), 32'd3);
    next_cycle(); rst = 1'b1;
    next_cycle();
    exp_idx = 0; words = 0; ready = 1'b1; start = 1'b1;
    next_cycle(); start = 1'b0;
    run_to_done("t4_restart", 20);
    check_eq("t4_restart_words", 32'(words), 32'd4);

    // Large dump with ready toggling every cycle.
    next_cycle();
    b_start = 1'b1; b_ready = 1'b1;
    for (int k = 0; k < 5000 && b_dones == 0; k++) begin
      next_cycle();
      b_start = 1'b0;
      b_ready = ~b_ready;
    end
    repeat (4) next_cycle();
    check_eq("t5_words", 32'(b_words), 32'd1024);
    check_eq("t5_dones", 32'(b_dones), 32'd1);
    check_eq("t5_busy", 32'(b_busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
